// File: rtl/arm7tdmi_cp_issue.sv
// Coprocessor instruction issue unit: decodes CDP/MRC/MCR/LDC/STC, runs the
// request/busy handshake with the coprocessor and produces completion or undef.

package arm7tdmi_pkg;
  typedef enum logic [2:0] {
    CP_CDP = 3'd0,
    CP_MCR = 3'd1,
    CP_MRC = 3'd2,
    CP_LDC = 3'd3,
    CP_STC = 3'd4
  } cp_op_t;
endpackage

module arm7tdmi_cp_issue
  import arm7tdmi_pkg::*;
#(
  parameter int unsigned MAX_BUSY = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rd_data,
  input  logic        flush,
  output logic        instr_done,
  output logic        undef_trap,
  output logic        cp_en,
  output cp_op_t      cp_op,
  output logic [3:0]  cp_num,
  output logic [3:0]  cp_crn,
  output logic [3:0]  cp_crm,
  output logic [2:0]  cp_op1,
  output logic [2:0]  cp_op2,
  output logic [31:0] cp_data_out,
  input  logic        cp_busy,
  input  logic        cp_absent,
  input  logic [31:0] cp_data_in,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        nzcv_en,
  output logic [3:0]  nzcv
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic        undef_q, undef_d;
  cp_op_t      op_q;
  logic [3:0]  num_q, crn_q, crm_q, rd_q;
  logic [2:0]  op1_q, op2_q;
  logic [31:0] data_out_q, cap_q;

  cp_op_t      dec_op;
  logic        dec_valid;
  logic        accept;
  logic        cap_en;
  logic        mrc_done;
  logic        unused_instr;

  assign unused_instr = ^instr[31:28];

  always_comb begin
    dec_valid = 1'b1;
    dec_op    = CP_CDP;
    if (instr[27:24] == 4'b1110) begin
      if (instr[4]) begin
        dec_op = instr[20] ? CP_MRC : CP_MCR;
      end else begin
        dec_op = CP_CDP;
      end
    end else if (instr[27:25] == 3'b110) begin
      dec_op = instr[20] ? CP_LDC : CP_STC;
    end else begin
      dec_valid = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    undef_d    = 1'b0;
    accept     = 1'b0;
    cap_en     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // While an undef pulse is out, upstream is still holding the trapped instruction.
          if (instr_valid && !undef_q) begin
            if (dec_valid) begin
              accept  = 1'b1;
              state_d = ISSUE;
            end else begin
              undef_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cp_absent) begin
            undef_d = 1'b1;
            state_d = IDLE;
          end else if (cp_busy) begin
            busy_cnt_d = 8'd0;
            state_d    = WAIT;
          end else begin
            cap_en  = 1'b1;
            state_d = DONE;
          end
        end
        WAIT: begin
          busy_cnt_d = busy_cnt_q + 8'd1;
          if (!cp_busy) begin
            cap_en  = 1'b1;
            state_d = DONE;
          end else if ((32'(busy_cnt_q) + 32'd1) >= MAX_BUSY) begin
            undef_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_cnt_q <= 8'd0;
      undef_q    <= 1'b0;
      op_q       <= CP_CDP;
      num_q      <= 4'd0;
      crn_q      <= 4'd0;
      crm_q      <= 4'd0;
      rd_q       <= 4'd0;
      op1_q      <= 3'd0;
      op2_q      <= 3'd0;
      data_out_q <= 32'd0;
      cap_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      undef_q    <= undef_d;
      if (accept) begin
        op_q       <= dec_op;
        num_q      <= instr[11:8];
        crn_q      <= instr[19:16];
        crm_q      <= instr[3:0];
        rd_q       <= instr[15:12];
        op1_q      <= instr[23:21];
        op2_q      <= instr[7:5];
        data_out_q <= rd_data;
      end
      if (cap_en) begin
        cap_q <= cp_data_in;
      end
    end
  end

  assign cp_en       = (state_q == ISSUE) || (state_q == WAIT);
  assign cp_op       = op_q;
  assign cp_num      = num_q;
  assign cp_crn      = crn_q;
  assign cp_crm      = crm_q;
  assign cp_op1      = op1_q;
  assign cp_op2      = op2_q;
  assign cp_data_out = data_out_q;

  // flush wins over any completion or trap in the same cycle.
  assign instr_done = (state_q == DONE) && !flush;
  assign undef_trap = undef_q && !flush;
  assign mrc_done   = (state_q == DONE) && (op_q == CP_MRC) && !flush;
  assign wb_en      = mrc_done && (rd_q != 4'd15);
  assign nzcv_en    = mrc_done && (rd_q == 4'd15);
  assign wb_rd      = rd_q;
  assign wb_data    = cap_q;
  assign nzcv       = cap_q[31:28];

endmodule

// File: tb/tb_arm7tdmi_cp_issue.sv
// Directed bench for arm7tdmi_cp_issue: vector table of single instructions
// plus hand-written flush and reset sequences.

module tb_arm7tdmi_cp_issue;
  import arm7tdmi_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] rd_data;
  logic        flush;
  logic        instr_done;
  logic        undef_trap;
  logic        cp_en;
  cp_op_t      cp_op;
  logic [3:0]  cp_num, cp_crn, cp_crm;
  logic [2:0]  cp_op1, cp_op2;
  logic [31:0] cp_data_out;
  logic        cp_busy;
  logic        cp_absent;
  logic [31:0] cp_data_in;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        nzcv_en;
  logic [3:0]  nzcv;

  int checks = 0;
  int errors = 0;

  arm7tdmi_cp_issue #(.MAX_BUSY(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .rd_data     (rd_data),
    .flush       (flush),
    .instr_done  (instr_done),
    .undef_trap  (undef_trap),
    .cp_en       (cp_en),
    .cp_op       (cp_op),
    .cp_num      (cp_num),
    .cp_crn      (cp_crn),
    .cp_crm      (cp_crm),
    .cp_op1      (cp_op1),
    .cp_op2      (cp_op2),
    .cp_data_out (cp_data_out),
    .cp_busy     (cp_busy),
    .cp_absent   (cp_absent),
    .cp_data_in  (cp_data_in),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .nzcv_en     (nzcv_en),
    .nzcv        (nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd_data;
    logic [31:0] din;
    logic        absent;
    int          busy;
    int          end_cyc;
    logic        undef;
    int          en_cnt;
    cp_op_t      op;
    logic [3:0]  num;
    logic [3:0]  crn;
    logic [3:0]  crm;
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        nzcv_en;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {16'd0, instr_done, undef_trap, cp_en, wb_en, nzcv_en, nzcv, cp_op,
                        cp_num}, 32'd0);
    chk({tag, "_fields"}, {11'd0, cp_crn, cp_crm, cp_op1, cp_op2, wb_rd}, 32'd0);
    chk({tag, "_data_out"}, cp_data_out, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  en_cnt;
    bit  ended;
    string n;
    en_cnt = 0;
    ended  = 0;
    n = $sformatf("v%0d", idx);
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = v.instr;
    rd_data     = v.rd_data;
    cp_data_in  = v.din;
    cp_absent   = v.absent;
    cp_busy     = 1'b0;
    for (int c = 0; c < 40 && !ended; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        cp_busy = (c <= v.busy);
      end
      @(negedge clk);
      if (cp_en) begin
        en_cnt++;
        chk({n, "_op"}, 32'(cp_op), 32'(v.op));
        chk({n, "_num"}, 32'(cp_num), 32'(v.num));
        chk({n, "_crn"}, 32'(cp_crn), 32'(v.crn));
        chk({n, "_crm"}, 32'(cp_crm), 32'(v.crm));
        chk({n, "_op1"}, 32'(cp_op1), 32'(v.op1));
        chk({n, "_op2"}, 32'(cp_op2), 32'(v.op2));
        chk({n, "_data_out"}, cp_data_out, v.rd_data);
      end
      if (instr_done || undef_trap) begin
        ended = 1;
        chk({n, "_end_cycle"}, c, v.end_cyc);
        chk({n, "_excl"}, 32'(instr_done & undef_trap), 32'd0);
        chk({n, "_undef"}, 32'(undef_trap), 32'(v.undef));
        chk({n, "_done"}, 32'(instr_done), 32'(!v.undef));
        chk({n, "_cp_en_end"}, 32'(cp_en), 32'd0);
        chk({n, "_en_cnt"}, en_cnt, v.en_cnt);
        chk({n, "_wb_en"}, 32'(wb_en), 32'(v.wb_en));
        chk({n, "_nzcv_en"}, 32'(nzcv_en), 32'(v.nzcv_en));
        if (v.wb_en) begin
          chk({n, "_wb_rd"}, 32'(wb_rd), 32'(v.wb_rd));
          chk({n, "_wb_data"}, wb_data, v.wb_data);
        end
        if (v.nzcv_en) begin
          chk({n, "_nzcv"}, 32'(nzcv), 32'(v.nzcv));
        end
        instr_valid = 1'b0;
      end
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no instr_done or undef_trap within 40 cycles", n);
      instr_valid = 1'b0;
    end
    cp_busy   = 1'b0;
    cp_absent = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'hEE103F10, 32'h0, 32'h41007000, 1'b0, 0, 2, 1'b0, 1, CP_MRC,
                 4'hF, 4'h0, 4'h0, 3'd0, 3'd0, 1'b1, 4'd3, 32'h41007000, 1'b0, 4'h0};
    vecs[1]  = '{32'hEE010F10, 32'h00001005, 32'hDEADBEEF, 1'b0, 0, 2, 1'b0, 1, CP_MCR,
                 4'hF, 4'h1, 4'h0, 3'd0, 3'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};
    vecs[2]  = '{32'hEE103E10, 32'h0, 32'h41007000, 1'b1, 0, 2, 1'b1, 1, CP_MRC,
                 4'hE, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};
    vecs[3]  = '{32'hEE105F10, 32'h77, 32'h12345678, 1'b0, 3, 5, 1'b0, 4, CP_MRC,
                 4'hF, 4'h0, 4'h0, 3'd0, 3'd0, 1'b1, 4'd5, 32'h12345678, 1'b0, 4'h0};
    vecs[4]  = '{32'hEE103F10, 32'h0, 32'h1, 1'b0, 100, 18, 1'b1, 17, CP_MRC,
                 4'hF, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};
    vecs[5]  = '{32'hEE10FF10, 32'h0, 32'hA0000000, 1'b0, 0, 2, 1'b0, 1, CP_MRC,
                 4'hF, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'hA};
    vecs[6]  = '{32'hEE3213A6, 32'hCAFE0001, 32'h5, 1'b0, 0, 2, 1'b0, 1, CP_CDP,
                 4'h3, 4'h2, 4'h6, 3'd1, 3'd5, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};
    vecs[7]  = '{32'hED912300, 32'h10, 32'h5, 1'b0, 0, 2, 1'b0, 1, CP_LDC,
                 4'h3, 4'h1, 4'h0, 3'd4, 3'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};
    vecs[8]  = '{32'hEC812300, 32'h20, 32'h5, 1'b0, 0, 2, 1'b0, 1, CP_STC,
                 4'h3, 4'h1, 4'h0, 3'd4, 3'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};
    vecs[9]  = '{32'hE0812300, 32'h0, 32'h0, 1'b0, 0, 1, 1'b1, 0, CP_CDP,
                 4'h0, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};
    vecs[10] = '{32'hEE010F10, 32'h99, 32'h0, 1'b0, 1, 3, 1'b0, 2, CP_MCR,
                 4'hF, 4'h1, 4'h0, 3'd0, 3'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'h0};

    rst_n       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    rd_data     = 32'h0;
    flush       = 1'b0;
    cp_busy     = 1'b0;
    cp_absent   = 1'b0;
    cp_data_in  = 32'h0;
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i);
    end

    // Flush while waiting on a busy coprocessor.
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = 32'hEE105F10;
    rd_data     = 32'h0;
    cp_data_in  = 32'h11111111;
    cp_busy     = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    flush       = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("flush_wait_cp_en", 32'(cp_en), 32'd1);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    cp_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_wait_quiet", {27'd0, cp_en, instr_done, undef_trap, wb_en, nzcv_en}, 32'd0);
    end

    // Flush in the completion cycle suppresses instr_done and writeback.
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = 32'hEE103F10;
    cp_data_in  = 32'h41007000;
    repeat (2) @(posedge clk);
    #1;
    flush       = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_quiet", {29'd0, instr_done, wb_en, undef_trap}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done_after", {29'd0, cp_en, instr_done, wb_en}, 32'd0);

    // Reset during WAIT clears everything immediately.
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = 32'hEE103F10;
    rd_data     = 32'h00000055;
    cp_busy     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wait_cp_en", 32'(cp_en), 32'd1);
    chk("rst_wait_data_out", cp_data_out, 32'h00000055);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    instr_valid = 1'b0;
    cp_busy     = 1'b0;
    rd_data     = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
